bus_select_arbiter: RTL and testbench
=====================================

Name: bus_select_arbiter

Overview:
- Parametrised successor to the fixed 24-source bus-select encoder in the datapath.
- Converts the per-source "drive bus" strobes (R0out..Cout style) into a registered bus-mux select index.
- New behaviour: selectable fixed-priority or round-robin arbitration, a valid flag, a hold/freeze input, and registered multi-driver conflict detection with a saturating counter.
- Sits between the control unit and the 32-bit bus multiplexer.

Parameters:
- NUM_SRC, 24, number of bus sources; bit i of the request vector maps to select code i (0..15 = R0..R15, 16 = HI, 17 = LO, 18 = Zhigh, 19 = Zlow, 20 = PC, 21 = MDR, 22 = InPort, 23 = C).
- SEL_W, 5, select width; must equal ceil(log2(NUM_SRC)), minimum 1.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- CNT_W, 8, conflict counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- src_req  in  NUM_SRC  per-source drive request; bit i = source i wants the bus.
- hold  in  1  freeze select, valid and round-robin pointer.
- conflict_clr  in  1  synchronous clear of conflict_cnt.
- sel  out  SEL_W  registered bus-mux select code.
- sel_valid  out  1  registered; 1 = sel reflects a request sampled last cycle.
- conflict  out  1  registered; 1 = more than one src_req bit was set last cycle.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles.

Behaviour:
- Reset (async assert, sync-safe deassert at a clk edge): sel=0, sel_valid=0, conflict=0, conflict_cnt=0, rr_ptr=0.
- Latency: exactly 1 clk from src_req to sel/sel_valid/conflict.
- No request (src_req==0), hold=0: sel keeps its previous value (matches the legacy encoder); sel_valid<=0; rr_ptr unchanged.
- Single request: sel<=index; sel_valid<=1. This holds in both modes.
- Fixed-priority mode (RR_MODE=0): the lowest set index wins. rr_ptr is unused and stays 0.
- Round-robin mode (RR_MODE=1):
  - The winner is the first set bit at index >= rr_ptr, wrapping to index 0.
  - After a grant, rr_ptr <= (winner+1) mod NUM_SRC. When the winner is NUM_SRC-1, rr_ptr wraps to 0.
- hold=1:
  - sel, sel_valid and rr_ptr keep their values.
  - conflict and conflict_cnt still update from the current src_req.
- Conflict detection:
  - conflict<=1 when popcount(src_req)>=2, otherwise 0. Independent of hold and mode.
  - conflict_cnt increments on each conflict cycle and saturates at 2^CNT_W-1 with no wrap.
  - conflict_clr=1 forces conflict_cnt<=0. If a conflict occurs in the same cycle, clear wins (result 0).
- Asserting reset_n low mid-stream returns every output to its reset value immediately. It does not wait for clk.
- Out-of-range codes (NUM_SRC..2^SEL_W-1) are never produced.

Decomposition:
- Shared package cpu_bus_pkg:
  - source index constants SRC_R0..SRC_C (0..23);
  - NUM_BUS_SRC=24;
  - BUS_SEL_W=5;
  - a sel_t typedef for the select code.
- One sub-module, find_first_set:
  - combinational, parameter N;
  - inputs: vector and start index;
  - outputs: found flag and index of the first set bit at or after start, wrapping.
- Fixed-priority mode drives start with 0; round-robin mode drives start with rr_ptr. The top level holds all registers and the popcount>=2 test.

Test Plan:
- Reset then src_req=1<<20 (PC) for one cycle -> next cycle sel=20, sel_valid=1, conflict=0; following cycle with src_req=0 -> sel=20, sel_valid=0.
- RR_MODE=0, src_req has bits 3 and 17 set -> sel=3, conflict=1, conflict_cnt=1. Repeated 300 cycles with CNT_W=8 -> conflict_cnt saturates at 255.
- RR_MODE=1, src_req bits 2, 5 and 23 held high -> sel sequence 2, 5, 23, 2, 5 on consecutive cycles; each cycle conflict=1.
- hold=1 with sel=5 while src_req=1<<9 -> sel stays 5 and rr_ptr unchanged. hold=0 -> next cycle sel=9.
- conflict_clr=1 in the same cycle as a 2-bit request with conflict_cnt=10 -> conflict_cnt=0, conflict=1.
- reset_n pulsed low between clk edges while sel=21, sel_valid=1 -> outputs read 0 before the next edge; after release, the first request is granted normally (rr_ptr=0).

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared bus-source definitions for the datapath bus multiplexer and its select arbiter.
package cpu_bus_pkg;

  localparam int unsigned NUM_BUS_SRC    = 24;
  localparam int unsigned BUS_SEL_W      = 5;
  localparam int unsigned CONFLICT_CNT_W = 8;

  typedef logic [BUS_SEL_W-1:0] sel_t;

  localparam sel_t SRC_R0     = sel_t'(0);
  localparam sel_t SRC_R1     = sel_t'(1);
  localparam sel_t SRC_R2     = sel_t'(2);
  localparam sel_t SRC_R3     = sel_t'(3);
  localparam sel_t SRC_R4     = sel_t'(4);
  localparam sel_t SRC_R5     = sel_t'(5);
  localparam sel_t SRC_R6     = sel_t'(6);
  localparam sel_t SRC_R7     = sel_t'(7);
  localparam sel_t SRC_R8     = sel_t'(8);
  localparam sel_t SRC_R9     = sel_t'(9);
  localparam sel_t SRC_R10    = sel_t'(10);
  localparam sel_t SRC_R11    = sel_t'(11);
  localparam sel_t SRC_R12    = sel_t'(12);
  localparam sel_t SRC_R13    = sel_t'(13);
  localparam sel_t SRC_R14    = sel_t'(14);
  localparam sel_t SRC_R15    = sel_t'(15);
  localparam sel_t SRC_HI     = sel_t'(16);
  localparam sel_t SRC_LO     = sel_t'(17);
  localparam sel_t SRC_ZHIGH  = sel_t'(18);
  localparam sel_t SRC_ZLOW   = sel_t'(19);
  localparam sel_t SRC_PC     = sel_t'(20);
  localparam sel_t SRC_MDR    = sel_t'(21);
  localparam sel_t SRC_INPORT = sel_t'(22);
  localparam sel_t SRC_C      = sel_t'(23);

endpackage

// File: rtl/bus_select_arbiter_if.sv
// Control-unit <-> bus-select arbiter signal bundle.
interface bus_select_arbiter_if
  import cpu_bus_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_BUS_SRC,
  parameter int unsigned SEL_W   = BUS_SEL_W,
  parameter int unsigned CNT_W   = CONFLICT_CNT_W
) ();

  logic [NUM_SRC-1:0] src_req;
  logic               hold;
  logic               conflict_clr;
  logic [SEL_W-1:0]   sel;
  logic               sel_valid;
  logic               conflict;
  logic [CNT_W-1:0]   conflict_cnt;

  // Control unit side.
  modport master (
    output src_req, hold, conflict_clr,
    input  sel, sel_valid, conflict, conflict_cnt
  );

  // Arbiter side.
  modport slave (
    input  src_req, hold, conflict_clr,
    output sel, sel_valid, conflict, conflict_cnt
  );

endinterface

// File: rtl/bus_select_arbiter_ffs.sv
// Circular find-first-set: first set bit of vec_i at or after start_i, wrapping past N-1 to 0.
module find_first_set #(
  parameter  int unsigned N  = 24,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec_i,
  input  logic [IW-1:0] start_i,
  output logic          found_c,
  output logic [IW-1:0] idx_c
);

  logic [IW:0] pos;

  // Scan offsets high to low so the smallest offset from start_i wins.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    pos     = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = {1'b0, start_i} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (vec_i[IW'(pos)]) begin
        found_c = 1'b1;
        idx_c   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/bus_select_arbiter.sv
// Registered bus-mux select generator: fixed-priority or round-robin grant among drive strobes,
// with hold/freeze and saturating multi-driver conflict counting.
module bus_select_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_BUS_SRC,
  parameter int unsigned SEL_W   = BUS_SEL_W,
  parameter int unsigned RR_MODE = 0,
  parameter int unsigned CNT_W   = CONFLICT_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bus_select_arbiter_if.slave  bus
);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0] ffs_start;
  logic             ffs_found;
  logic [SEL_W-1:0] ffs_idx;
  logic             multi_req;

  assign ffs_start = (RR_MODE != 0) ? rr_ptr_q : '0;

  find_first_set #(.N(NUM_SRC)) u_ffs (
    .vec_i   (bus.src_req),
    .start_i (ffs_start),
    .found_c (ffs_found),
    .idx_c   (ffs_idx)
  );

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_req = |(bus.src_req & (bus.src_req - NUM_SRC'(1)));

  always_comb begin
    sel_d      = sel_q;
    valid_d    = valid_q;
    rr_ptr_d   = rr_ptr_q;
    conflict_d = multi_req;
    cnt_d      = cnt_q;

    if (!bus.hold) begin
      if (ffs_found) begin
        sel_d   = ffs_idx;
        valid_d = 1'b1;
        if (RR_MODE != 0) begin
          rr_ptr_d = (ffs_idx == SEL_W'(NUM_SRC - 1)) ? '0 : ffs_idx + SEL_W'(1);
        end
      end else begin
        valid_d = 1'b0;
      end
    end

    // Clear has priority over a same-cycle conflict.
    if (bus.conflict_clr) begin
      cnt_d = '0;
    end else if (multi_req && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q      <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
    end else begin
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.sel          = sel_q;
  assign bus.sel_valid    = valid_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Scoreboard bench: one fixed-priority and one round-robin arbiter driven by the same stimulus.
module tb_bus_select_arbiter;
  import cpu_bus_pkg::*;

  typedef struct {
    int sel;
    bit valid;
    bit conf;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  int m_sel[2];
  int m_ptr[2];
  int m_cnt[2];
  bit m_valid[2];

  bus_select_arbiter_if #(.NUM_SRC(24), .SEL_W(5), .CNT_W(8)) if0 ();
  bus_select_arbiter_if #(.NUM_SRC(24), .SEL_W(5), .CNT_W(8)) if1 ();

  bus_select_arbiter #(.NUM_SRC(24), .SEL_W(5), .RR_MODE(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0));
  bus_select_arbiter #(.NUM_SRC(24), .SEL_W(5), .RR_MODE(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_sel[m] = 0; m_ptr[m] = 0; m_cnt[m] = 0; m_valid[m] = 1'b0;
    end
  endtask

  // Arbitration rules stated directly: popcount, circular scan from start, modular pointer.
  task automatic model(input int m, input logic [23:0] r, input logic h, input logic c);
    exp_t e;
    int   start;
    int   w;
    int   idx;
    logic [23:0] sh;
    bit   conf;
    conf = ($countones(r) >= 2);
    if (c) m_cnt[m] = 0;
    else if (conf && m_cnt[m] < 255) m_cnt[m] = m_cnt[m] + 1;
    if (!h) begin
      if (r != '0) begin
        start = (m == 1) ? m_ptr[m] : 0;
        w = -1;
        for (int k = 0; k < 24; k++) begin
          idx = (start + k) % 24;
          sh = r >> idx;
          if (w < 0 && sh[0]) w = idx;
        end
        m_sel[m] = w;
        m_valid[m] = 1'b1;
        if (m == 1) m_ptr[m] = (w + 1) % 24;
      end else begin
        m_valid[m] = 1'b0;
      end
    end
    e.sel = m_sel[m]; e.valid = m_valid[m]; e.conf = conf; e.cnt = m_cnt[m];
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic step(input logic [23:0] r, input logic h, input logic c);
    @(negedge clk);
    if0.src_req = r; if0.hold = h; if0.conflict_clr = c;
    if1.src_req = r; if1.hold = h; if1.conflict_clr = c;
    model(0, r, h, c);
    model(1, r, h, c);
  endtask

  task automatic at_out();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if0.src_req = '0; if0.hold = 1'b0; if0.conflict_clr = 1'b0;
    if1.src_req = '0; if1.hold = 1'b0; if1.conflict_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_sel0", int'(if0.sel), 0);
    chk("rst_valid1", int'(if1.sel_valid), 0);
    chk("rst_cnt0", int'(if0.conflict_cnt), 0);
    reset_n = 1'b1;
  endtask

  task automatic cmp(input string tag, input exp_t e, input int s, input logic v,
                     input logic cf, input int cn);
    chk({tag, "_sel"}, s, e.sel);
    chk({tag, "_valid"}, int'(v), int'(e.valid));
    chk({tag, "_conflict"}, int'(cf), int'(e.conf));
    chk({tag, "_cnt"}, cn, e.cnt);
  endtask

  // Monitor: each driven cycle has exactly one expected result one edge later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && q0.size() > 0) begin
        e = q0.pop_front();
        cmp("fp", e, int'(if0.sel), if0.sel_valid, if0.conflict, int'(if0.conflict_cnt));
      end
      if (reset_n && q1.size() > 0) begin
        e = q1.pop_front();
        cmp("rr", e, int'(if1.sel), if1.sel_valid, if1.conflict, int'(if1.conflict_cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] r;
    logic h;
    logic c;
    int rr_exp[5];
    rr_exp[0] = 2; rr_exp[1] = 5; rr_exp[2] = 23; rr_exp[3] = 2; rr_exp[4] = 5;
    idle_inputs();
    model_reset();
    do_reset();

    // Single PC request, then idle: select is retained, valid drops.
    step(24'(1) << SRC_PC, 1'b0, 1'b0);
    at_out();
    chk("pc_sel", int'(if0.sel), 20);
    chk("pc_valid", int'(if0.sel_valid), 1);
    chk("pc_conflict", int'(if0.conflict), 0);
    step('0, 1'b0, 1'b0);
    at_out();
    chk("idle_sel", int'(if0.sel), 20);
    chk("idle_valid", int'(if0.sel_valid), 0);

    // Fixed priority with two drivers, then saturation.
    do_reset();
    r = (24'(1) << 3) | (24'(1) << 17);
    step(r, 1'b0, 1'b0);
    at_out();
    chk("fp_lowest", int'(if0.sel), 3);
    chk("fp_conf", int'(if0.conflict), 1);
    chk("fp_cnt1", int'(if0.conflict_cnt), 1);
    repeat (299) step(r, 1'b0, 1'b0);
    at_out();
    chk("cnt_sat", int'(if0.conflict_cnt), 255);

    // Round-robin rotation over three persistent requesters.
    do_reset();
    r = (24'(1) << 2) | (24'(1) << 5) | (24'(1) << 23);
    for (int i = 0; i < 5; i++) begin
      step(r, 1'b0, 1'b0);
      at_out();
      chk("rr_seq", int'(if1.sel), rr_exp[i]);
      chk("rr_conf", int'(if1.conflict), 1);
    end

    // Hold freezes select and pointer.
    do_reset();
    step(24'(1) << 5, 1'b0, 1'b0);
    step(24'(1) << 9, 1'b1, 1'b0);
    at_out();
    chk("hold_sel_rr", int'(if1.sel), 5);
    chk("hold_sel_fp", int'(if0.sel), 5);
    step((24'(1) << 9) | (24'(1) << 4), 1'b0, 1'b0);
    at_out();
    chk("unhold_rr", int'(if1.sel), 9);
    chk("unhold_fp", int'(if0.sel), 4);

    // Clear beats a same-cycle conflict.
    do_reset();
    r = (24'(1) << 1) | (24'(1) << 11);
    repeat (10) step(r, 1'b0, 1'b0);
    at_out();
    chk("cnt10", int'(if0.conflict_cnt), 10);
    step(r, 1'b0, 1'b1);
    at_out();
    chk("clr_cnt", int'(if0.conflict_cnt), 0);
    chk("clr_conf", int'(if0.conflict), 1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = 24'(1) << $urandom_range(0, 23);
        2: r = 24'($urandom & $urandom & $urandom);
        default: r = 24'($urandom);
      endcase
      h = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 15) == 0);
      step(r, h, c);
    end

    // Asynchronous reset between edges.
    step(24'(1) << SRC_MDR, 1'b0, 1'b0);
    at_out();
    chk("mdr_sel", int'(if1.sel), 21);
    chk("mdr_valid", int'(if1.sel_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_sel", int'(if1.sel), 0);
    chk("arst_valid", int'(if1.sel_valid), 0);
    chk("arst_conf", int'(if0.conflict), 0);
    chk("arst_cnt", int'(if0.conflict_cnt), 0);
    model_reset();
    reset_n = 1'b1;
    step((24'(1) << 7) | (24'(1) << 3), 1'b0, 1'b0);
    at_out();
    chk("post_rst_rr", int'(if1.sel), 3);

    step('0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
